// File: rtl/clock_display_scan_if.sv
// Bus between the timekeeper/edit logic (master) and the six-digit display scanner (slave).
// Carries binary time fields and the edit selector in, and segment/digit drive plus the refresh pulse out.
interface clock_display_scan_if;
   logic [7:0] seconds;
   logic [7:0] minutes;
   logic [7:0] hours;
   logic [1:0] EDIT_SEL;
   logic [6:0] SEG;
   logic       DP;
   logic [5:0] DIGIT_EN;
   logic       UPDATE;

   modport master (output seconds, minutes, hours, EDIT_SEL,
                   input  SEG, DP, DIGIT_EN, UPDATE);
   modport slave  (input  seconds, minutes, hours, EDIT_SEL,
                   output SEG, DP, DIGIT_EN, UPDATE);
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH.MM.SS display driver: snapshots the time once per scan, converts it to BCD
// with a double-dabble FSM, and scans active-low segments/digits with edit-field blinking.
module clock_display_scan #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int SCAN_HZ    = 1000
) (
   input  logic                 CLK,
   input  logic                 RST,
   clock_display_scan_if.slave  bus
);
   localparam int DWELL   = CLOCK_FREQ / SCAN_HZ;
   localparam int BLINK   = CLOCK_FREQ / 4;
   localparam int DWELL_W = $clog2(DWELL);
   localparam int BLINK_W = $clog2(BLINK);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK - 1);
   localparam logic [3:0] DIG_DASH  = 4'd10;
   localparam logic [3:0] DIG_BLANK = 4'd11;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [2:0]         shift_cnt_q, shift_cnt_d;
   logic [19:0]        sec_q, sec_d, min_q, min_d, hr_q, hr_d;
   logic [23:0]        buf_q, buf_d;
   logic [2:0]         scan_idx_q, scan_idx_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_q, blink_d;
   logic               first_q, first_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;
   logic [5:0]         digit_en_q, digit_en_d;
   logic               update_q, update_d;
   logic               snap_s;
   logic [3:0]         digit_s;
   logic [1:0]         field_s;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         4'd10:   s = 7'h3F;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // One double-dabble iteration: {hundreds, tens, ones, binary} adjusted then shifted left.
   function automatic logic [19:0] dabble_step(input logic [19:0] v);
      logic [19:0] a;
      a = v;
      for (int i = 0; i < 3; i++) begin
         if (a[8 + 4*i +: 4] >= 4'd5) begin
            a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
         end
      end
      return {a[18:0], 1'b0};
   endfunction

   function automatic logic [7:0] field_digits(input logic [19:0] v);
      if (v[19:16] != 4'd0) begin
         return {DIG_DASH, DIG_DASH};
      end else begin
         return v[15:8];
      end
   endfunction

   // Next-state logic: scan/blink timing, conversion FSM and registered display outputs.
   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      buf_d       = buf_q;
      update_d    = 1'b0;
      first_d     = 1'b0;
      scan_idx_d  = scan_idx_q;
      dwell_d     = dwell_q + DWELL_W'(1);
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      blink_d     = blink_q;

      if (dwell_q == DWELL_LAST) begin
         dwell_d    = '0;
         scan_idx_d = (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
      end else begin
         scan_idx_d = scan_idx_q;
      end

      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end else begin
         blink_d     = blink_q;
      end

      snap_s = first_q || ((scan_idx_q == 3'd5) && (dwell_q == DWELL_LAST));

      case (state_q)
         IDLE: begin
            if (snap_s) begin
               sec_d       = {12'd0, bus.seconds};
               min_d       = {12'd0, bus.minutes};
               hr_d        = {12'd0, bus.hours};
               shift_cnt_d = 3'd0;
               state_d     = SHIFT;
            end else begin
               state_d     = IDLE;
            end
         end
         SHIFT: begin
            sec_d       = dabble_step(sec_q);
            min_d       = dabble_step(min_q);
            hr_d        = dabble_step(hr_q);
            shift_cnt_d = shift_cnt_q + 3'd1;
            if (shift_cnt_q == 3'd7) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            buf_d    = {field_digits(hr_q), field_digits(min_q), field_digits(sec_q)};
            update_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      case (scan_idx_q)
         3'd0:    begin digit_s = buf_q[3:0];   field_s = 2'd1; digit_en_d = 6'b111110; end
         3'd1:    begin digit_s = buf_q[7:4];   field_s = 2'd1; digit_en_d = 6'b111101; end
         3'd2:    begin digit_s = buf_q[11:8];  field_s = 2'd2; digit_en_d = 6'b111011; end
         3'd3:    begin digit_s = buf_q[15:12]; field_s = 2'd2; digit_en_d = 6'b110111; end
         3'd4:    begin digit_s = buf_q[19:16]; field_s = 2'd3; digit_en_d = 6'b101111; end
         3'd5:    begin digit_s = buf_q[23:20]; field_s = 2'd3; digit_en_d = 6'b011111; end
         default: begin digit_s = DIG_BLANK;    field_s = 2'd0; digit_en_d = 6'b111111; end
      endcase

      // EDIT_SEL of 0 never matches a field, so nothing blanks when no field is being edited.
      if (blink_q && (bus.EDIT_SEL == field_s) && (field_s != 2'd0)) begin
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end else begin
         seg_d = seg_code(digit_s);
         dp_d  = !((scan_idx_q == 3'd2) || (scan_idx_q == 3'd4));
      end
   end

   // State registers with synchronous active-low reset; reset aborts any conversion in flight.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= IDLE;
         shift_cnt_q <= 3'd0;
         sec_q       <= 20'd0;
         min_q       <= 20'd0;
         hr_q        <= 20'd0;
         buf_q       <= 24'd0;
         scan_idx_q  <= 3'd0;
         dwell_q     <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         first_q     <= 1'b1;
         seg_q       <= 7'h40;
         dp_q        <= 1'b1;
         digit_en_q  <= 6'b111110;
         update_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         buf_q       <= buf_d;
         scan_idx_q  <= scan_idx_d;
         dwell_q     <= dwell_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         first_q     <= first_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         digit_en_q  <= digit_en_d;
         update_q    <= update_d;
      end
   end

   assign bus.SEG      = seg_q;
   assign bus.DP       = dp_q;
   assign bus.DIGIT_EN = digit_en_q;
   assign bus.UPDATE   = update_q;
endmodule
